// File: rtl/mips_arith_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the arithmetic datapath.
// All outputs come from registers or the state register; no input reaches an output combinationally.
module mips_arith_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter int          COUNT_W       = 16,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    input  logic               dec_except,
    input  logic               dec_we,
    output logic               alu_capture,
    output logic               regfile_we,
    output logic [31:0]        pc,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         cause,
    output logic [31:0]        exc_pc,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0]         CAUSE_NONE    = 2'd0;
    localparam logic [1:0]         CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0]         CAUSE_TIMEOUT = 2'd2;
    localparam logic [7:0]         TMO_LAST      = 8'(FETCH_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] RET_MAX       = '1;
    localparam logic [COUNT_W-1:0] RET_ONE       = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          inst_q, inst_d;
    logic [1:0]           cause_q, cause_d;
    logic [31:0]          exc_pc_q, exc_pc_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 we_q, we_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            cause_q   <= CAUSE_NONE;
            exc_pc_q  <= '0;
            retired_q <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            cause_q   <= cause_d;
            exc_pc_q  <= exc_pc_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        cause_d   = cause_q;
        exc_pc_d  = exc_pc_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        we_d      = we_q;

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A valid word on the last allowed cycle still wins over the timeout.
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    tmo_d   = '0;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d    = '0;
                    cause_d  = CAUSE_TIMEOUT;
                    exc_pc_d = pc_q;
                    state_d  = S_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                // Latch the write enable so the WB strobe does not follow the decoder input.
                we_d = dec_we;
                if (dec_except) begin
                    cause_d  = CAUSE_ILLEGAL;
                    exc_pc_d = pc_q;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                pc_d = pc_q + 32'd4;
                if (retired_q != RET_MAX) begin
                    retired_d = retired_q + RET_ONE;
                end
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (clear) begin
                    pc_d    = RESET_PC;
                    cause_d = CAUSE_NONE;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign alu_capture = (state_q == S_EXEC);
    assign regfile_we  = (state_q == S_WB) && we_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted      = (state_q == S_HALT);
    assign cause       = cause_q;
    assign exc_pc      = exc_pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_mips_arith_sequencer.sv
// Directed bench for mips_arith_sequencer with a small stand-in decoder.
module tb_mips_arith_sequencer;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          CW  = 4;   // narrow counter so saturation is reachable quickly

    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_ADD  = 32'h012A_4020;
    localparam logic [31:0] I_SUB  = 32'h012A_4022;
    localparam logic [31:0] I_XORI = 32'h3908_00FF;
    localparam logic [31:0] I_SW   = 32'hAD09_0000;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic          clk = 1'b0;
    logic          reset, start, stop, clear;
    logic          imem_req, imem_valid;
    logic [31:0]   imem_addr, imem_rdata, inst, pc, exc_pc;
    logic          dec_except, dec_we, alu_capture, regfile_we, busy, halted;
    logic [1:0]    cause;
    logic [CW-1:0] retired;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mips_arith_sequencer #(
        .RESET_PC(RPC), .COUNT_W(CW), .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata), .inst(inst), .dec_except(dec_except), .dec_we(dec_we),
        .alu_capture(alu_capture), .regfile_we(regfile_we), .pc(pc), .busy(busy),
        .halted(halted), .cause(cause), .exc_pc(exc_pc), .retired(retired)
    );

    // Minimal decoder: a few R-type/I-type ops write, sw does not, anything else traps.
    always_comb begin
        dec_except = 1'b0;
        dec_we     = 1'b0;
        case (inst[31:26])
            6'h00: begin
                if (inst[5:0] == 6'h20 || inst[5:0] == 6'h22 || inst[5:0] == 6'h24 ||
                    inst[5:0] == 6'h25 || inst[5:0] == 6'h2A) dec_we = 1'b1;
                else dec_except = 1'b1;
            end
            6'h08, 6'h0C, 6'h0D, 6'h0E: dec_we = 1'b1;
            6'h2B: dec_we = 1'b0;
            default: dec_except = 1'b1;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pc"},      pc,               RPC);
        check_val({tag, "_inst"},    inst,             32'h0);
        check_val({tag, "_cause"},   32'(cause),       32'h0);
        check_val({tag, "_exc_pc"},  exc_pc,           32'h0);
        check_val({tag, "_retired"}, 32'(retired),     32'h0);
        check_val({tag, "_strobes"}, {29'h0, imem_req, alu_capture, regfile_we}, 32'h0);
        check_val({tag, "_busy_halt"}, {30'h0, busy, halted}, 32'h0);
    endtask

    // Enter in FETCH (1 time unit after an edge); leaves in FETCH or IDLE after writeback.
    task automatic do_inst(input string tag, input logic [31:0] word, input logic exp_we,
                           input logic stop_wb);
        int caps;
        check_val({tag, "_req"}, 32'(imem_req), 32'h1);
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_valid = 1'b0;
        check_val({tag, "_inst"}, inst, word);
        caps = int'(alu_capture);
        step();
        caps += int'(alu_capture);
        step();
        caps += int'(alu_capture);
        check_val({tag, "_we"}, 32'(regfile_we), 32'(exp_we));
        stop = stop_wb;
        step();
        stop = 1'b0;
        caps += int'(alu_capture);
        check_val({tag, "_caps"}, 32'(caps), 32'h1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        step();

        // 1: addi fetched immediately, 4-cycle latency
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t1_fetch_req", 32'(imem_req), 32'h1);
        check_val("t1_addr", imem_addr, RPC);
        imem_valid = 1'b1; imem_rdata = I_ADDI;
        step();
        imem_valid = 1'b0;
        check_val("t1_dec_inst", inst, I_ADDI);
        check_val("t1_dec_strobes", {30'h0, imem_req, alu_capture}, 32'h0);
        step();
        check_val("t1_exec_cap", 32'(alu_capture), 32'h1);
        step();
        check_val("t1_wb_we", {30'h0, regfile_we, alu_capture}, 32'h2);
        step();
        check_val("t1_pc", pc, RPC + 32'd4);
        check_val("t1_retired", 32'(retired), 32'h1);
        check_val("t1_refetch", 32'(imem_req), 32'h1);

        // 2: streamed add/sub/xori, then sw (no write) with stop in WB
        do_inst("t2_add", I_ADD, 1'b1, 1'b0);
        do_inst("t2_sub", I_SUB, 1'b1, 1'b0);
        do_inst("t2_xori", I_XORI, 1'b1, 1'b0);
        check_val("t2_pc", pc, RPC + 32'd16);
        check_val("t2_retired", 32'(retired), 32'h4);
        do_inst("t2_sw", I_SW, 1'b0, 1'b1);
        check_val("t2_stop_busy", 32'(busy), 32'h0);
        check_val("t2_stop_pc", pc, RPC + 32'd20);

        // 3: illegal opcode; stop during FETCH and DECODE must not matter
        start = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b1;
        imem_valid = 1'b1; imem_rdata = I_BAD;
        step();
        imem_valid = 1'b0;
        check_val("t3_dec_we", 32'(regfile_we), 32'h0);
        step();
        stop = 1'b0;
        check_val("t3_halted", {30'h0, busy, halted}, 32'h1);
        check_val("t3_cause", 32'(cause), 32'h1);
        check_val("t3_exc_pc", exc_pc, RPC + 32'd20);
        check_val("t3_pc_held", pc, RPC + 32'd20);
        check_val("t3_retired", 32'(retired), 32'h5);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t3_start_ignored", 32'(halted), 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("t3_clear_state", {30'h0, busy, halted}, 32'h0);
        check_val("t3_clear_pc", pc, RPC);
        check_val("t3_clear_cause", 32'(cause), 32'h0);
        check_val("t3_exc_kept", exc_pc, RPC + 32'd20);

        // 4a: fifteen fetch cycles without valid -> timeout
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        check_val("t4_still_fetch", {30'h0, imem_req, halted}, 32'h2);
        step();
        check_val("t4_halted", 32'(halted), 32'h1);
        check_val("t4_cause", 32'(cause), 32'h2);
        check_val("t4_exc_pc", exc_pc, RPC);
        check_val("t4_req_off", 32'(imem_req), 32'h0);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // 4b: valid arrives on the 15th cycle -> accepted
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        imem_valid = 1'b1; imem_rdata = I_ADDI;
        step();
        imem_valid = 1'b0;
        check_val("t4b_no_fault", {30'h0, busy, halted}, 32'h2);
        check_val("t4b_inst", inst, I_ADDI);
        check_val("t4b_cause", 32'(cause), 32'h0);
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("t4b_pc", pc, RPC + 32'd4);
        check_val("t4b_retired", 32'(retired), 32'h6);

        // 5: start and stop together in IDLE -> start wins; stop in WB of second instruction
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_val("t5_start_wins", 32'(imem_req), 32'h1);
        check_val("t5_addr", imem_addr, RPC + 32'd4);
        do_inst("t5_add", I_ADD, 1'b1, 1'b0);
        do_inst("t5_sub", I_SUB, 1'b1, 1'b1);
        check_val("t5_pc", pc, RPC + 32'd12);
        check_val("t5_busy", 32'(busy), 32'h0);
        check_val("t5_retired", 32'(retired), 32'h8);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t5_resume_addr", imem_addr, RPC + 32'd12);

        // 6a: asynchronous reset in EXEC
        imem_valid = 1'b1; imem_rdata = I_XORI;
        step();
        imem_valid = 1'b0;
        step();
        check_val("t6_exec", 32'(alu_capture), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        step();
        reset = 1'b1;
        step();
        check_val("t6_no_wb_retired", 32'(retired), 32'h0);
        check_val("t6_no_wb_pc", pc, RPC);

        // 6b: retired counter saturates at all-ones
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            do_inst($sformatf("t6_sat%0d", i), I_ADDI, 1'b1, 1'b0);
            check_val($sformatf("t6_ret%0d", i), 32'(retired), (i < 15) ? 32'(i) : 32'd15);
        end
        check_val("t6_pc_after", pc, RPC + 32'd68);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
